// File: rtl/ps2_keycode_rx_if.sv
// Bundle between the PS/2 receiver and its keyboard lines / consumer.
// master = receiver side; slave = line driver and btn consumer.
interface ps2_keycode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] btn;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        frame_err;

  modport master (input ps2_clk, ps2_data, output btn, rx_byte, rx_done, frame_err);
  modport slave  (output ps2_clk, ps2_data, input btn, rx_byte, rx_done, frame_err);
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: line conditioning, 11-bit frame capture and a
// make/break/E0 decoder that tracks the currently held key on btn[15:0].

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Output flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ps2_keycode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input logic            clk,
  input logic            reset,
  ps2_keycode_rx_if.master bus
);
  localparam int NUM_LINES = 2;
  localparam int TW        = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [NUM_LINES-1:0] raw, flt;
  logic                 clk_prev, fall_tick, data_f;

  assign raw = {bus.ps2_data, bus.ps2_clk};

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_flt [NUM_LINES-1:0] (
    .clk  (clk),
    .reset(reset),
    .din  (raw),
    .dout (flt)
  );

  assign data_f    = flt[1];
  assign fall_tick = clk_prev & ~flt[0];

  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          done_d, err_d;

  logic [7:0]    rx_byte_q;
  logic          rx_done_q, frame_err_q;
  logic          ext_q, brk_q;
  logic [15:0]   held_q;
  logic [15:0]   cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev <= 1'b1;
      state_q  <= IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      clk_prev <= flt[0];
      state_q  <= state_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // A fall_tick always beats the timeout terminal count.
    if (state_q == IDLE || fall_tick) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
      tcnt_d  = '0;
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (fall_tick) begin
      case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          sh_d  = {data_f, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_f;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_f && (^{sh_q, par_q})) done_d = 1'b1;
          else                            err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cand = ext_q ? {8'hE0, rx_byte_q} : {8'h00, rx_byte_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
    end else begin
      rx_done_q   <= done_d;
      frame_err_q <= err_d;
      if (done_d) rx_byte_q <= sh_q;

      // A corrupted frame drops any pending prefix so it cannot mis-release.
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_done_q) begin
        case (rx_byte_q)
          8'hE0:   ext_q <= 1'b1;
          8'hF0:   brk_q <= 1'b1;
          default: begin
            if (brk_q) begin
              if (cand == held_q) held_q <= '0;
            end else begin
              held_q <= cand;
            end
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.btn       = {16'h0000, held_q};
  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: vector table, hand-written corner sequences and a
// randomized key-event run scored against a held-key model.
module tb_ps2_keycode_rx;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 20000;
  localparam int HALF       = 15;

  logic clk;
  logic reset;
  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_err = 0, n_chg = 0;
  logic [31:0] btn_prev = '0;
  logic        done_prev = 1'b0;
  logic        rst_prev = 1'b0;

  // Pulse counting; btn may change only one cycle after an rx_done pulse.
  always @(negedge clk) begin
    if (bus.rx_done)   n_done++;
    if (bus.frame_err) n_err++;
    if (reset && rst_prev && (bus.btn !== btn_prev)) begin
      n_chg++;
      total++;
      if (!done_prev) begin
        bad++;
        $display("FAIL btn_latency act=%h prev=%h required rx_done in prior cycle", bus.btn, btn_prev);
      end
    end
    btn_prev  = bus.btn;
    done_prev = bus.rx_done;
    rst_prev  = reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      if (glitch && (i == 3 || i == 7)) begin
        wait_clks(4);
        bus.ps2_clk = 1'b0;
        wait_clks(3);
        bus.ps2_clk = 1'b1;
        wait_clks(HALF - 7);
      end else begin
        wait_clks(HALF);
      end
      bus.ps2_clk = 1'b0;
      wait_clks(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic p;
    p = bad_par ? (^b) : ~(^b);
    send_bits({1'b1, p, b, 1'b0}, 11, glitch);
    wait_clks(HALF + 10);
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    logic [31:0] ebtn;
    logic [7:0]  erx;
    int          edone;
    int          eerr;
  } vec_t;

  vec_t vt [25];

  initial begin
    int d0, e0, c0;
    logic [15:0] held;
    logic [7:0]  code, lastrx;
    bit          ext, rel;

    vt[0]  = '{8'h1C, 1'b0, 32'h0000001C, 8'h1C, 1, 0};
    vt[1]  = '{8'hE0, 1'b0, 32'h0000001C, 8'hE0, 1, 0};
    vt[2]  = '{8'h72, 1'b0, 32'h0000E072, 8'h72, 1, 0};
    vt[3]  = '{8'hE0, 1'b0, 32'h0000E072, 8'hE0, 1, 0};
    vt[4]  = '{8'hF0, 1'b0, 32'h0000E072, 8'hF0, 1, 0};
    vt[5]  = '{8'h72, 1'b0, 32'h00000000, 8'h72, 1, 0};
    vt[6]  = '{8'hE0, 1'b0, 32'h00000000, 8'hE0, 1, 0};
    vt[7]  = '{8'h75, 1'b0, 32'h0000E075, 8'h75, 1, 0};
    vt[8]  = '{8'hE0, 1'b0, 32'h0000E075, 8'hE0, 1, 0};
    vt[9]  = '{8'hF0, 1'b0, 32'h0000E075, 8'hF0, 1, 0};
    vt[10] = '{8'h75, 1'b0, 32'h00000000, 8'h75, 1, 0};
    vt[11] = '{8'h72, 1'b1, 32'h00000000, 8'h75, 0, 1};
    vt[12] = '{8'hE0, 1'b0, 32'h00000000, 8'hE0, 1, 0};
    vt[13] = '{8'h72, 1'b0, 32'h0000E072, 8'h72, 1, 0};
    vt[14] = '{8'hE0, 1'b0, 32'h0000E072, 8'hE0, 1, 0};
    vt[15] = '{8'hF0, 1'b0, 32'h0000E072, 8'hF0, 1, 0};
    vt[16] = '{8'h75, 1'b0, 32'h0000E072, 8'h75, 1, 0};
    vt[17] = '{8'hE0, 1'b0, 32'h0000E072, 8'hE0, 1, 0};
    vt[18] = '{8'hF0, 1'b0, 32'h0000E072, 8'hF0, 1, 0};
    vt[19] = '{8'h72, 1'b0, 32'h00000000, 8'h72, 1, 0};
    vt[20] = '{8'hE0, 1'b0, 32'h00000000, 8'hE0, 1, 0};
    vt[21] = '{8'hF0, 1'b1, 32'h00000000, 8'hE0, 0, 1};
    vt[22] = '{8'h72, 1'b0, 32'h00000072, 8'h72, 1, 0};
    vt[23] = '{8'hF0, 1'b0, 32'h00000072, 8'hF0, 1, 0};
    vt[24] = '{8'h72, 1'b0, 32'h00000000, 8'h72, 1, 0};

    // Reset held across line activity
    reset = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 5; i++) begin
      bus.ps2_clk  = 1'($urandom_range(0, 1));
      bus.ps2_data = 1'($urandom_range(0, 1));
      wait_clks(1);
    end
    chk("reset_btn", bus.btn, 32'h0);
    chk("reset_rx_byte", {24'h0, bus.rx_byte}, 32'h0);
    chk("reset_pulses", n_done + n_err, 0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(40);
    chk("post_reset_pulses", n_done + n_err, 0);

    foreach (vt[i]) begin
      d0 = n_done;
      e0 = n_err;
      send_byte(vt[i].b, vt[i].bad_par, 1'b0);
      chk($sformatf("vec%0d_btn", i), bus.btn, vt[i].ebtn);
      chk($sformatf("vec%0d_rx", i), {24'h0, bus.rx_byte}, {24'h0, vt[i].erx});
      chk($sformatf("vec%0d_done", i), n_done - d0, vt[i].edone);
      chk($sformatf("vec%0d_err", i), n_err - e0, vt[i].eerr);
    end

    // Short glitches on ps2_clk must not add bits
    d0 = n_done;
    e0 = n_err;
    send_byte(8'h1C, 1'b0, 1'b1);
    chk("glitch_rx", {24'h0, bus.rx_byte}, 32'h1C);
    chk("glitch_btn", bus.btn, 32'h1C);
    chk("glitch_pulses", {n_done - d0, n_err - e0}, {32'd1, 32'd0});

    // Reset in the middle of an all-ones frame: remainder is ignored in IDLE
    d0 = n_done;
    e0 = n_err;
    fork
      send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 11, 1'b0);
      begin
        wait_clks(HALF * 5);
        reset = 1'b0;
        wait_clks(5);
        reset = 1'b1;
      end
    join
    wait_clks(HALF + 40);
    chk("midrst_btn", bus.btn, 32'h0);
    chk("midrst_rx", {24'h0, bus.rx_byte}, 32'h0);
    chk("midrst_pulses", {n_done - d0, n_err - e0}, {32'd0, 32'd0});

    // Timeout: start + 4 data bits, then a silent line
    d0 = n_done;
    e0 = n_err;
    send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 5, 1'b0);
    wait_clks(TIMEOUT + 10);
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_done", n_done - d0, 0);
    send_byte(8'h29, 1'b0, 1'b0);
    chk("after_timeout_rx", {24'h0, bus.rx_byte}, 32'h29);
    chk("after_timeout_btn", bus.btn, 32'h29);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h29, 1'b0, 1'b0);
    chk("release29_btn", bus.btn, 32'h0);

    // Typematic repeat: one btn change over three E0 72 pairs
    d0 = n_done;
    e0 = n_err;
    c0 = n_chg;
    for (int r = 0; r < 3; r++) begin
      send_byte(8'hE0, 1'b0, 1'b0);
      send_byte(8'h72, 1'b0, 1'b0);
    end
    chk("typematic_btn", bus.btn, 32'h0000E072);
    chk("typematic_chg", n_chg - c0, 1);
    chk("typematic_done", n_done - d0, 6);
    chk("typematic_err", n_err - e0, 0);

    // Random key events against a held-key model
    held   = 16'hE072;
    lastrx = 8'h72;
    for (int k = 0; k < 25; k++) begin
      ext  = 1'($urandom_range(0, 1));
      code = 8'($urandom_range(1, 127));
      rel  = ($urandom_range(0, 2) == 0);
      if (rel && held != 16'h0 && $urandom_range(0, 1) == 1) begin
        code = held[7:0];
        ext  = (held[15:8] == 8'hE0);
      end
      if (ext) send_byte(8'hE0, 1'b0, 1'b0);
      if (rel) send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(code, 1'b0, 1'b0);
      lastrx = code;
      if (!rel)                                      held = {ext ? 8'hE0 : 8'h00, code};
      else if (held == {ext ? 8'hE0 : 8'h00, code})  held = 16'h0;
      chk($sformatf("rnd%0d_btn", k), bus.btn, {16'h0, held});
      chk($sformatf("rnd%0d_rx", k), {24'h0, bus.rx_byte}, {24'h0, lastrx});
      if ($urandom_range(0, 4) == 0) begin
        e0 = n_err;
        send_byte(8'($urandom), 1'b1, 1'b0);
        chk($sformatf("rnd%0d_perr", k), n_err - e0, 1);
        chk($sformatf("rnd%0d_perr_rx", k), {24'h0, bus.rx_byte}, {24'h0, lastrx});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
